// File: rtl/gppcu_instr_issue_if.sv
// Instruction-memory, issue and LSU-completion signals between the issue sequencer and the core.
// Port names follow the sequencer's point of view (o* driven by the sequencer, i* driven by the core).
interface gppcu_instr_issue_if #(
    parameter int PC_W = 10
);
    logic            oIMEM_RD;
    logic [PC_W-1:0] oIMEM_ADDR;
    logic [31:0]     iIMEM_RDATA;
    logic            iIMEM_VALID;
    logic            oISSUE_VALID;
    logic [4:0]      oOPC;
    logic [3:0]      oRD;
    logic [3:0]      oRA;
    logic [3:0]      oRB;
    logic [14:0]     oIMM;
    logic            iLSU_DONE;

    modport master (
        output oIMEM_RD, oIMEM_ADDR, oISSUE_VALID, oOPC, oRD, oRA, oRB, oIMM,
        input  iIMEM_RDATA, iIMEM_VALID, iLSU_DONE
    );

    modport slave (
        input  oIMEM_RD, oIMEM_ADDR, oISSUE_VALID, oOPC, oRD, oRA, oRB, oIMM,
        output iIMEM_RDATA, iIMEM_VALID, iLSU_DONE
    );
endinterface

// File: rtl/gppcu_instr_issue.sv
// Fetch/issue sequencer for one GPPCU core: fetch, split and issue words, stall on float/local-memory ops.
// Optional perf counters (oCYC_CNT, oINSTR_CNT) exist only when GPPCU_ISSUE_PERF_CNT_EN is defined.
module gppcu_instr_issue #(
    parameter int PC_W    = 10,
    parameter int FPU_LAT = 4
) (
    input  logic                iCLK,
    input  logic                iRSTn,
    input  logic                iSTART,
    input  logic [PC_W-1:0]     iSTART_PC,
    output logic                oBUSY,
    output logic                oDONE,
    output logic                oERR,
`ifdef GPPCU_ISSUE_PERF_CNT_EN
    output logic [31:0]         oCYC_CNT,
    output logic [31:0]         oINSTR_CNT,
`endif
    gppcu_instr_issue_if.master bus
);
    localparam logic [4:0] OPC_LDL  = 5'd22;
    localparam logic [4:0] OPC_STL  = 5'd24;
    localparam logic [4:0] OPC_HALT = 5'd31;
    localparam int         CNT_W    = (FPU_LAT > 2) ? $clog2(FPU_LAT) : 1;
    localparam logic [CNT_W-1:0] FPU_LOAD = CNT_W'((FPU_LAT > 0) ? FPU_LAT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_WAIT, ST_ISSUE, ST_STALL_FPU, ST_STALL_MEM, ST_DONE
    } stateT;

    stateT            state, stateNext;
    logic [PC_W-1:0]  pc;
    logic [31:0]      instr;
    logic             err;
    logic [CNT_W-1:0] stallCnt;
    logic [3:0]       lastRd, lastRa, lastRb;
    logic [14:0]      lastImm;

    logic [4:0] opc;
    logic       isReserved, isFloat, isMem, issuing, startAccept;

    always_comb begin
        opc         = instr[31:27];
        isReserved  = opc inside {[5'd25:5'd30]};
        isFloat     = opc inside {[5'd14:5'd19], 5'd21};
        isMem       = (opc == OPC_LDL) || (opc == OPC_STL);
        issuing     = (state == ST_ISSUE);
        startAccept = (state == ST_IDLE) && iSTART;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives stateNext and no latch is inferred.
        stateNext = state;
        unique case (state)
            ST_IDLE:      if (iSTART) stateNext = ST_FETCH;
            ST_FETCH:     stateNext = ST_WAIT;
            ST_WAIT:      if (bus.iIMEM_VALID)
                              stateNext = (bus.iIMEM_RDATA[31:27] == OPC_HALT) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:     if (isFloat && (FPU_LAT > 0)) stateNext = ST_STALL_FPU;
                          else if (isMem)               stateNext = ST_STALL_MEM;
                          else                          stateNext = ST_FETCH;
            ST_STALL_FPU: if (stallCnt == '0) stateNext = ST_FETCH;
            ST_STALL_MEM: if (bus.iLSU_DONE) stateNext = ST_FETCH;
            ST_DONE:      stateNext = ST_IDLE;
            default:      stateNext = ST_IDLE;
        endcase
    end

    // NOTE: all registers update with non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state    <= ST_IDLE;
            pc       <= '0;
            instr    <= '0;
            err      <= 1'b0;
            stallCnt <= '0;
            lastRd   <= '0;
            lastRa   <= '0;
            lastRb   <= '0;
            lastImm  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                ST_IDLE: if (iSTART) begin
                    pc  <= iSTART_PC;
                    err <= 1'b0;
                end
                ST_WAIT: if (bus.iIMEM_VALID) instr <= bus.iIMEM_RDATA;
                ST_ISSUE: begin
                    pc       <= pc + PC_W'(1);
                    stallCnt <= FPU_LOAD;
                    lastRd   <= instr[26:23];
                    lastRa   <= instr[22:19];
                    lastRb   <= instr[18:15];
                    lastImm  <= instr[14:0];
                    if (isReserved) err <= 1'b1;
                end
                ST_STALL_FPU: stallCnt <= stallCnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Fields show the current word while issuing and hold the last issued values otherwise.
    assign oBUSY            = (state != ST_IDLE);
    assign oDONE            = (state == ST_DONE);
    assign oERR             = err;
    assign bus.oIMEM_RD     = (state == ST_FETCH);
    assign bus.oIMEM_ADDR   = pc;
    assign bus.oISSUE_VALID = issuing;
    assign bus.oOPC         = (issuing && !isReserved) ? opc : 5'd0;
    assign bus.oRD          = issuing ? instr[26:23] : lastRd;
    assign bus.oRA          = issuing ? instr[22:19] : lastRa;
    assign bus.oRB          = issuing ? instr[18:15] : lastRb;
    assign bus.oIMM         = issuing ? instr[14:0]  : lastImm;

`ifdef GPPCU_ISSUE_PERF_CNT_EN
    logic [31:0] cycCnt, instrCnt;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cycCnt   <= '0;
            instrCnt <= '0;
        end else if (startAccept) begin
            cycCnt   <= '0;
            instrCnt <= '0;
        end else begin
            if (oBUSY && (cycCnt != '1))     cycCnt   <= cycCnt + 32'd1;
            if (issuing && (instrCnt != '1)) instrCnt <= instrCnt + 32'd1;
        end
    end

    assign oCYC_CNT   = cycCnt;
    assign oINSTR_CNT = instrCnt;
`endif
endmodule
